// File: rtl/grant_burst_pkg.sv
// Shared types and defaults for the grant-driven burst controller.
package grant_burst_pkg;

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_e;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int BURST_LEN_DEF = 4;

  // Index width that stays at least one bit wide for degenerate N=1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder with exact-one and more-than-one flags.
module onehot_enc
  import grant_burst_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid,
  output logic          multi
);

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(vec & (vec - 1'b1));
  assign valid = (|vec) & ~multi;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = idx | IW'(i);
    end
  end

endmodule

// File: rtl/grant_burst_ctrl.sv
// Latches a one-hot grant as owner and streams a fixed-length burst of the
// owner's data over a valid/ready channel, with per-requester ack/done pulses.
module grant_burst_ctrl
  import grant_burst_pkg::*;
#(
  parameter  int N_REQ     = N_REQ_DEF,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int BURST_LEN = BURST_LEN_DEF,
  localparam int ID_W      = idx_w(N_REQ),
  localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        GNT,
  input  logic [N_REQ*DATA_W-1:0] REQ_DATA,
  output logic                    BUSY,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [DATA_W-1:0]       OUT_DATA,
  output logic [ID_W-1:0]         OUT_ID,
  output logic                    OUT_LAST,
  output logic [N_REQ-1:0]        DATA_ACK,
  output logic [N_REQ-1:0]        DONE,
  output logic                    ERR
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_e                          state_q, state_d;
  logic   [ID_W-1:0]               owner_q, owner_d;
  logic   [CNT_W-1:0]              cnt_q, cnt_d;
  logic                            err_q, err_d;
  logic   [ID_W-1:0]               gnt_idx;
  logic                            gnt_one, gnt_multi;
  logic   [N_REQ-1:0]              owner_oh;
  logic   [N_REQ-1:0][DATA_W-1:0]  req_data;

  assign req_data = REQ_DATA;
  assign ERR      = err_q;

  onehot_enc #(.N(N_REQ)) u_gnt_enc (
    .vec   (GNT),
    .idx   (gnt_idx),
    .valid (gnt_one),
    .multi (gnt_multi)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) owner_oh[i] = (owner_q == ID_W'(i));
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    BUSY      = 1'b0;
    OUT_VALID = 1'b0;
    OUT_DATA  = '0;
    OUT_ID    = '0;
    OUT_LAST  = 1'b0;
    DATA_ACK  = '0;
    DONE      = '0;
    case (state_q)
      IDLE: begin
        // A malformed grant is flagged and dropped rather than guessed at.
        if (gnt_multi) begin
          err_d = 1'b1;
        end else if (gnt_one) begin
          owner_d = gnt_idx;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        BUSY      = 1'b1;
        OUT_VALID = 1'b1;
        OUT_ID    = owner_q;
        OUT_DATA  = req_data[owner_q];
        OUT_LAST  = (cnt_q == LAST_CNT);
        if (OUT_READY) begin
          DATA_ACK = owner_oh;
          cnt_d    = cnt_q + CNT_W'(1);
          if (OUT_LAST) state_d = FIN;
        end
      end
      FIN: begin
        BUSY    = 1'b1;
        DONE    = owner_oh;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
